// File: rtl/sar_pkg.sv
// Shared types and defaults for the successive-approximation search block.
package sar_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEARCH = 2'd1,
    ST_VERIFY = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/sar_search.sv
// Successive-approximation search against an external comparator, MSB first.
// Optional macro SAR_SEARCH_EARLY_EXIT_EN: finish as soon as the comparator reports equality.
import sar_pkg::*;

module sar_search #(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] trial,
  input  logic             cmp_eq,
  input  logic             cmp_gt,
  input  logic             cmp_lt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             found,
  output logic             err,
  output logic [1:0]       dbg_state
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t            state;
  logic [IW-1:0]     bit_idx;
  logic [WIDTH-1:0]  bit_mask;
  logic              one_hot;
  logic              gt_ok;
  logic              eq_ok;

  // Comparator handshake: cmp_* answer the current trial in the same cycle;
  // trial itself depends only on registered state, so there is no loop.
  assign bit_mask = {{(WIDTH-1){1'b0}}, 1'b1} << bit_idx;
  assign trial    = (state == ST_SEARCH) ? (result | bit_mask) : result;

  // A malformed response counts as neither gt nor eq.
  assign one_hot = (cmp_eq ^ cmp_gt ^ cmp_lt) & ~(cmp_eq & cmp_gt & cmp_lt);
  assign gt_ok   = one_hot & cmp_gt;
  assign eq_ok   = one_hot & cmp_eq;

  assign busy      = (state == ST_SEARCH) || (state == ST_VERIFY);
  assign done      = (state == ST_DONE);
  assign dbg_state = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      result  <= '0;
      bit_idx <= IW'(WIDTH - 1);
      found   <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state   <= ST_SEARCH;
            result  <= '0;
            bit_idx <= IW'(WIDTH - 1);
            found   <= 1'b0;
            err     <= 1'b0;
          end
        end
        ST_SEARCH: begin
          if (!one_hot) err <= 1'b1;
`ifdef SAR_SEARCH_EARLY_EXIT_EN
          if (eq_ok) begin
            result <= trial;
            found  <= 1'b1;
            state  <= ST_DONE;
          end else begin
            if (!gt_ok) result <= trial;
            bit_idx <= bit_idx - IW'(1);
            if (bit_idx == '0) state <= ST_VERIFY;
          end
`else
          if (!gt_ok) result <= trial;
          bit_idx <= bit_idx - IW'(1);
          if (bit_idx == '0) state <= ST_VERIFY;
`endif
        end
        ST_VERIFY: begin
          if (!one_hot) err <= 1'b1;
          found <= eq_ok;
          state <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/sar_search.md
SAR_SEARCH -- requirements
Module: sar_search

Interface
- REQ-001 SHALL have parameter: WIDTH, 4, operand/result width in bits (legal range 2..16).
- REQ-002 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
- REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
- REQ-004 SHALL have port: start  input  1  request a new search; sampled only in IDLE.
- REQ-005 SHALL have port: trial  output  WIDTH  candidate value driven to the external comparator's first operand.
- REQ-006 SHALL have ports: cmp_eq, cmp_gt, cmp_lt  input  1 each  external comparator result of trial vs hidden target (gt means trial > target), combinational, same cycle.
- REQ-007 SHALL have port: busy  output  1  high in SEARCH and VERIFY.
- REQ-008 SHALL have port: done  output  1  one-cycle pulse when result is valid.
- REQ-009 SHALL have port: result  output  WIDTH  found value; holds after done until the next accepted start.
- REQ-010 SHALL have port: found  output  1  cmp_eq observed for the final value.
- REQ-011 SHALL have port: err  output  1  sticky flag for a non-one-hot comparator response; cleared on the next accepted start.

Function
- REQ-012 SHALL implement FSM states IDLE, SEARCH, VERIFY, DONE; transitions are IDLE->SEARCH on start, SEARCH->VERIFY after bit 0, VERIFY->DONE, and DONE->IDLE unconditionally.
- REQ-013 SHALL, on accepting start, clear result, found and err, and set the bit index to WIDTH-1.
- REQ-014 SHALL drive trial = result | (1 << bit index) in SEARCH, and trial = result in all other states.
- REQ-015 SHALL, in each SEARCH cycle, clear the trial bit when cmp_gt=1 and otherwise keep it set, registering the outcome into result; then decrement the bit index.
- REQ-016 SHALL, in VERIFY, register found = cmp_eq.
- REQ-017 SHALL assert done for exactly the DONE cycle; with start sampled at edge 0, done is high in cycle WIDTH+2.
- REQ-018 SHALL ignore start outside IDLE, with no restart and no error.
- REQ-019 SHALL, on any SEARCH/VERIFY sample where {cmp_eq,cmp_gt,cmp_lt} is not one-hot, set err and treat the sample as not-gt and not-eq.
- REQ-020 SHALL drive outputs from registers or from state-only logic; trial SHALL NOT depend combinationally on the cmp_* inputs.

Reset
- REQ-021 SHALL, while rst_n=0, force state IDLE, result=0, trial=0, bit index=WIDTH-1, and busy=done=found=err=0, independent of clk.
- REQ-022 SHALL abort any search when reset is asserted mid-operation; the first start after release begins a fresh search with no residual state.

Configuration
- REQ-023 SHALL, with macro SAR_SEARCH_EARLY_EXIT_EN defined, on cmp_eq=1 in SEARCH register result=trial and found=1, skip VERIFY and go directly to DONE.
- REQ-024 SHALL, without SAR_SEARCH_EARLY_EXIT_EN, ignore cmp_eq in SEARCH except for the err check, so that latency is always WIDTH+2.

Structure
- REQ-025 SHALL place the state enum typedef and the default WIDTH constant in shared package sar_pkg.
- REQ-026 SHALL be a single module with no sub-module; the comparator is external, and the bench pairs the DUT with a behavioural comparator model.

Verification (WIDTH=4, bench comparator trial vs target)
- REQ-027 SHALL cover: target=5 -> trials 8,4,6,5 then verify 5; result=5, found=1, done at cycle 6, err=0.
- REQ-028 SHALL cover: target=0 -> trials 8,4,2,1 all gt, verify trial=0; result=0, found=1. Target=15 -> trials 8,12,14,15; result=15.
- REQ-029 SHALL cover: early-exit build, target=8 -> eq on first trial; done at cycle 2, result=8, found=1. Non-early-exit build -> done at cycle 6.
- REQ-030 SHALL cover: comparator forced to all-zero -> err=1, result=15, found=0. Next start -> err cleared.
- REQ-031 SHALL cover: rst_n pulsed low at cycle 3 of a search -> all outputs 0 immediately. Start pulsed at cycle 2 of a search -> ignored, completion timing unchanged.
